nexys_starship_repair_arb: RTL and testbench

- Shares the single switch-entry/submit resource (Sw3..Sw0 hex_combo plus submit button) among the four repair rooms (top, bottom, left, right).
- Grants one broken room at a time, round-robin.
- Presents the granted room's target combo for SSD/VGA display and checks the submitted code against it.
- Issues a one-cycle fix pulse to the owning room FSM, and enforces a repair timeout and a miss penalty.
- Sits between the room FSMs (TR/BR/LR/RR), the game FSM and the top-level display mux.

---
 rtl/nexys_starship_repair_arb.sv | 214 +++++++++++++++++++++
 tb/tb_nexys_starship_repair_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_repair_arb.sv
// nexys_starship_repair_arb
// Shares the single switch-entry / submit resource among the four repair
// rooms (top, bottom, left, right). One broken room is granted at a time;
// its target combo is presented for display and the submitted code is
// checked against it. A correct code produces a one-cycle fix pulse to the
// owning room, a wrong code or an expired grant starts a penalty window.
//
// Optional build macro: STARSHIP_ARB_PRIORITY_EN
//   defined   -> fixed priority top > btm > left > right (rr_ptr frozen)
//   undefined -> round-robin starting at rr_ptr (default)
//
// Handshake: req[i] is a level "room i is broken" request. grant is a
// one-hot level that stays high while the room is being served. A request
// is considered consumed only when fix[i] pulses. Dropping req[i] while it
// is granted withdraws it silently. The requester never needs to wait on
// grant before dropping req.
module nexys_starship_repair_arb #(
    parameter int TIMEOUT_TICKS  = 10,
    parameter int PENALTY_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        play_flag,
    input  logic        gameover_ctrl,
    input  logic [3:0]  req,
    input  logic [15:0] target_combo,
    input  logic [3:0]  hex_combo,
    input  logic        submit,
    input  logic        tick,
    output logic [3:0]  grant,
    output logic [3:0]  active_combo,
    output logic [3:0]  fix,
    output logic        timeout,
    output logic        miss,
    output logic [3:0]  miss_count,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        CHECK   = 2'd2,
        PENALTY = 2'd3
    } state_t;

    localparam int TIM_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] PEN_LAST = CNT_W'(PENALTY_CYCLES - 1);

    state_t             state, state_n;
    logic [1:0]         rr_ptr, rr_ptr_n;
    logic [1:0]         win, win_n;
    logic [3:0]         grant_n, active_n, fix_n, miss_count_n;
    logic               timeout_n, miss_n;
    logic [TIM_W-1:0]   timer, timer_n;
    logic [CNT_W-1:0]   pen_cnt, pen_cnt_n;
    logic [3:0]         captured, captured_n;

    logic [1:0]         scan_base;
    logic [1:0]         rr_adv;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [1:0]         cand;
    logic [3:0]         win_target;
    logic [3:0]         pick_target;

`ifdef STARSHIP_ARB_PRIORITY_EN
    // Fixed priority: always scan from top, pointer never moves.
    assign scan_base = 2'd0;
    assign rr_adv    = rr_ptr;
`else
    // Round-robin: scan from the pointer, release moves it past the winner.
    assign scan_base = rr_ptr;
    assign rr_adv    = win + 2'd1;
`endif

    assign win_target  = target_combo[{win, 2'b00} +: 4];
    assign pick_target = target_combo[{pick_idx, 2'b00} +: 4];
    assign state_dbg   = state;

    // Pick the first pending request scanning upward from scan_base with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = scan_base;
        cand       = scan_base;
        for (int i = 0; i < 4; i++) begin
            cand = scan_base + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; gameover overrides every state.
    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        win_n        = win;
        grant_n      = grant;
        active_n     = active_combo;
        fix_n        = 4'd0;
        timeout_n    = 1'b0;
        miss_n       = 1'b0;
        miss_count_n = miss_count;
        timer_n      = timer;
        pen_cnt_n    = pen_cnt;
        captured_n   = captured;

        if (gameover_ctrl) begin
            state_n  = IDLE;
            grant_n  = 4'd0;
            active_n = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (play_flag && pick_found) begin
                        win_n    = pick_idx;
                        grant_n  = 4'b0001 << pick_idx;
                        active_n = pick_target;
                        timer_n  = '0;
                        state_n  = SERVE;
                    end
                end
                SERVE: begin
                    active_n = win_target;
                    if (submit) begin
                        captured_n = hex_combo;
                        state_n    = CHECK;
                    end else if (tick) begin
                        if (timer == TIM_LAST) begin
                            timeout_n = 1'b1;
                            grant_n   = 4'd0;
                            active_n  = 4'd0;
                            rr_ptr_n  = rr_adv;
                            pen_cnt_n = '0;
                            state_n   = PENALTY;
                        end else begin
                            timer_n = timer + 1'b1;
                        end
                    end else if (!req[win]) begin
                        grant_n  = 4'd0;
                        active_n = 4'd0;
                        state_n  = IDLE;
                    end
                end
                CHECK: begin
                    grant_n  = 4'd0;
                    active_n = 4'd0;
                    rr_ptr_n = rr_adv;
                    if (captured == active_combo) begin
                        fix_n   = grant;
                        state_n = IDLE;
                    end else begin
                        miss_n    = 1'b1;
                        pen_cnt_n = '0;
                        state_n   = PENALTY;
                        if (miss_count != 4'hF) begin
                            miss_count_n = miss_count + 4'd1;
                        end
                    end
                end
                PENALTY: begin
                    if (pen_cnt == PEN_LAST) begin
                        state_n = IDLE;
                    end else begin
                        pen_cnt_n = pen_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    grant_n  = 4'd0;
                    active_n = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            rr_ptr       <= 2'd0;
            win          <= 2'd0;
            grant        <= 4'd0;
            active_combo <= 4'd0;
            fix          <= 4'd0;
            timeout      <= 1'b0;
            miss         <= 1'b0;
            miss_count   <= 4'd0;
            busy         <= 1'b0;
            timer        <= '0;
            pen_cnt      <= '0;
            captured     <= 4'd0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            win          <= win_n;
            grant        <= grant_n;
            active_combo <= active_n;
            fix          <= fix_n;
            timeout      <= timeout_n;
            miss         <= miss_n;
            miss_count   <= miss_count_n;
            busy         <= (state_n != IDLE);
            timer        <= timer_n;
            pen_cnt      <= pen_cnt_n;
            captured     <= captured_n;
        end
    end

endmodule

// File: tb/tb_nexys_starship_repair_arb.sv
// Testbench for nexys_starship_repair_arb (TIMEOUT_TICKS=3, PENALTY_CYCLES=20).
// A room-level reference model tracks the owner, ticks used and remaining
// cooldown as plain integers and predicts every registered output per edge.
module tb_nexys_starship_repair_arb;

    localparam int TO  = 3;
    localparam int PEN = 20;

    // ---------------- clock / reset / DUT ----------------
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        play_flag = 1'b0;
    logic        gameover_ctrl = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] target_combo = 16'd0;
    logic [3:0]  hex_combo = 4'd0;
    logic        submit = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  grant, active_combo, fix, miss_count;
    logic        timeout, miss, busy;
    logic [1:0]  state_dbg;

    always #5 Clk = ~Clk;

    nexys_starship_repair_arb #(
        .TIMEOUT_TICKS (TO),
        .PENALTY_CYCLES(PEN),
        .CNT_W         (5)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .play_flag    (play_flag),
        .gameover_ctrl(gameover_ctrl),
        .req          (req),
        .target_combo (target_combo),
        .hex_combo    (hex_combo),
        .submit       (submit),
        .tick         (tick),
        .grant        (grant),
        .active_combo (active_combo),
        .fix          (fix),
        .timeout      (timeout),
        .miss         (miss),
        .miss_count   (miss_count),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_owner;     // room being served, -1 when none
    bit         m_checking;  // a code was submitted, verdict on next edge
    logic [3:0] m_code;
    int         m_ticks;     // ticks consumed by the current grant
    int         m_cool;      // penalty edges still to wait
    int         m_next;      // room the next round-robin scan starts from
    logic [3:0] e_grant, e_active, e_fix, e_mcount;
    logic       e_timeout, e_miss, e_busy;

    function automatic logic [3:0] room_target(input int r);
        logic [15:0] t;
        t = target_combo;
        return t[r*4 +: 4];
    endfunction

    task automatic model_reset();
        m_owner = -1; m_checking = 0; m_code = 0; m_ticks = 0; m_cool = 0; m_next = 0;
        e_grant = 0; e_active = 0; e_fix = 0; e_timeout = 0; e_miss = 0;
        e_mcount = 0; e_busy = 0;
    endtask

    task automatic release_owner();
`ifndef STARSHIP_ARB_PRIORITY_EN
        m_next = (m_owner + 1) % 4;
`endif
        m_owner = -1; e_grant = 0; e_active = 0;
    endtask

    task automatic model_step();
        int base;
        if (!Reset) begin
            model_reset();
            return;
        end
        e_fix = 0; e_timeout = 0; e_miss = 0;
        if (gameover_ctrl) begin
            m_owner = -1; m_checking = 0; m_cool = 0; e_grant = 0; e_active = 0;
        end else if (m_checking) begin
            m_checking = 0;
            if (m_code == e_active) begin
                e_fix = 4'(1 << m_owner);
            end else begin
                e_miss = 1;
                if (e_mcount < 15) e_mcount = e_mcount + 1;
                m_cool = PEN;
            end
            release_owner();
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_owner >= 0) begin
            e_active = room_target(m_owner);
            if (submit) begin
                m_code = hex_combo;
                m_checking = 1;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == TO) begin
                    e_timeout = 1;
                    m_cool = PEN;
                    release_owner();
                end
            end else if (!req[m_owner]) begin
                m_owner = -1; e_grant = 0; e_active = 0;
            end
        end else if (play_flag) begin
`ifdef STARSHIP_ARB_PRIORITY_EN
            base = 0;
`else
            base = m_next;
`endif
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(base + k) % 4]) m_owner = (base + k) % 4;
            end
            if (m_owner >= 0) begin
                m_ticks = 0;
                e_grant = 4'(1 << m_owner);
                e_active = room_target(m_owner);
            end
        end
        e_busy = (m_owner >= 0) || (m_cool > 0);
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".grant"},   16'(grant),        16'(e_grant));
        check_eq({ph, ".active"},  16'(active_combo), 16'(e_active));
        check_eq({ph, ".fix"},     16'(fix),          16'(e_fix));
        check_eq({ph, ".timeout"}, 16'(timeout),      16'(e_timeout));
        check_eq({ph, ".miss"},    16'(miss),         16'(e_miss));
        check_eq({ph, ".mcount"},  16'(miss_count),   16'(e_mcount));
        check_eq({ph, ".busy"},    16'(busy),         16'(e_busy));
    endtask

    // ---------------- driver tasks ----------------
    // One clock edge; model and DUT advance together, outputs checked 1 ns later.
    task automatic step(input string ph);
        @(posedge Clk);
        model_step();
        #1;
        check_outputs(ph);
    endtask

    task automatic steps(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b0; submit = 0; tick = 0; gameover_ctrl = 0; req = 0;
        #1;
        model_reset();
        check_outputs("reset");
        step("reset_hold");
        Reset = 1'b1;
    endtask

    task automatic pulse_submit(input string ph, input logic [3:0] code);
        hex_combo = code; submit = 1'b1;
        step(ph);
        submit = 1'b0;
    endtask

    task automatic pulse_tick(input string ph);
        tick = 1'b1;
        step(ph);
        tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        check_outputs("por");
        do_reset();
        play_flag = 1'b1;

        // single room, correct code
        target_combo = 16'h000A; req = 4'b0001;
        step("s1_grant");
        pulse_submit("s1_submit", 4'hA);
        req = 4'b0000;
        steps("s1_fix", 3);

        // two rooms, both correct: top then bottom
        target_combo = 16'h0021; req = 4'b0011;
        step("s2_grant_top");
        pulse_submit("s2_sub_top", 4'h1);
        step("s2_fix_top");
        step("s2_grant_next");
        pulse_submit("s2_sub_next", room_target(m_owner < 0 ? 0 : m_owner));
        req = 4'b0000;
        steps("s2_tail", 3);

        // wrong code: miss, penalty, regrant
        do_reset();
        target_combo = 16'h0005; req = 4'b0001;
        step("s3_grant");
        pulse_submit("s3_submit", 4'h3);
        steps("s3_penalty", PEN + 3);
        req = 4'b0000;
        steps("s3_tail", 2);

        // timeout on top, then grant rotates to bottom
        do_reset();
        target_combo = 16'h0087; req = 4'b0011;
        step("s4_grant");
        pulse_tick("s4_tick1");
        pulse_tick("s4_tick2");
        pulse_tick("s4_tick3");
        steps("s4_penalty", PEN + 2);
        req = 4'b0000;
        steps("s4_tail", 2);

        // submit together with the final tick: check wins
        do_reset();
        target_combo = 16'h0009; req = 4'b0001;
        step("s5_grant");
        pulse_tick("s5_tick1");
        pulse_tick("s5_tick2");
        hex_combo = 4'h9; submit = 1'b1; tick = 1'b1;
        step("s5_both");
        submit = 1'b0; tick = 1'b0; req = 4'b0000;
        steps("s5_fix", 3);

        // requester withdraws while granted
        target_combo = 16'h0B00; req = 4'b0100;
        step("s6_grant");
        req = 4'b0000;
        steps("s6_drop", 3);

        // gameover during a grant, held, then released
        target_combo = 16'h0004; req = 4'b0001;
        step("s7_grant");
        gameover_ctrl = 1'b1; hex_combo = 4'h4; submit = 1'b1;
        step("s7_over");
        submit = 1'b0;
        steps("s7_hold", 4);
        gameover_ctrl = 1'b0;
        steps("s7_release", 2);

        // play_flag low blocks a new grant
        req = 4'b0000; steps("s8_idle", 2);
        play_flag = 1'b0; req = 4'b1000;
        steps("s8_blocked", 3);
        play_flag = 1'b1;
        step("s8_grant");

        // asynchronous reset while serving
        @(posedge Clk); #1;
        model_step();
        check_outputs("s9_serve");
        Reset = 1'b0;
        #1;
        model_reset();
        check_outputs("s9_async");
        steps("s9_hold", 2);
        Reset = 1'b1;
        req = 4'b0000;
        step("s9_after");

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) target_combo = 16'($urandom());
            play_flag     = ($urandom_range(0, 19) != 0);
            if (gameover_ctrl) gameover_ctrl = ($urandom_range(0, 3) != 0);
            else gameover_ctrl = ($urandom_range(0, 79) == 0);
            submit = ($urandom_range(0, 5) == 0);
            tick   = ($urandom_range(0, 2) == 0);
            if (m_owner >= 0 && $urandom_range(0, 1) == 1) hex_combo = room_target(m_owner);
            else hex_combo = 4'($urandom_range(0, 15));
            step("rand");
        end
        submit = 0; tick = 0; gameover_ctrl = 0;
        steps("drain", 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
